// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient width, reset coefficient set, load FSM states.
// Also provides the stored-word count and index-width helpers used to size the coefficient banks.
package fir_pkg;

   localparam int COEF_W_DEF = 21;
   localparam int NDEF       = 8;

   localparam logic [COEF_W_DEF-1:0] DEFAULT [NDEF] = '{
      21'h0B0000, 21'h098000, 21'h090000, 21'h0D2000,
      21'h0C0000, 21'h086000, 21'h0A4000, 21'h08F000
   };

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      PENDING = 2'd2
   } load_state_e;

   // A symmetric filter stores only the first half of the taps, rounded up.
   function automatic int nstore_calc(input int taps, input int symmetric);
      return (symmetric != 0) ? (taps + 1) / 2 : taps;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/banco_coeficientes_if.sv
// Coefficient bank bus: tap read port, host load stream and frame-boundary swap handshake.
// master = FIR controller/host side, slave = coefficient bank.
interface banco_coeficientes_if
   import fir_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF,
   parameter int TAPS   = 8
);
   localparam int AW = $clog2(TAPS);

   logic              rd_en;
   logic [AW-1:0]     contador_arriba;
   logic [COEF_W-1:0] coeficiente;
   logic              coef_valid;
   logic              load_valid;
   logic [COEF_W-1:0] load_data;
   logic              load_ready;
   logic              load_abort;
   logic              swap_req;
   logic              swap_done;
   logic              bank_sel;

   modport master (
      output rd_en, contador_arriba, load_valid, load_data, load_abort, swap_req,
      input  coeficiente, coef_valid, load_ready, swap_done, bank_sel
   );

   modport slave (
      input  rd_en, contador_arriba, load_valid, load_data, load_abort, swap_req,
      output coeficiente, coef_valid, load_ready, swap_done, bank_sel
   );

endinterface

// File: rtl/cargador_coeficientes.sv
// Load FSM for the shadow bank: sequences write indices and arms the bank swap once a set is complete.
// Zero-latency strobes; load_ready drops while a completed set waits for swap_req.
module cargador_coeficientes
   import fir_pkg::*;
#(
   parameter int NSTORE = 8,
   parameter int SW     = idx_width(NSTORE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic          load_abort,
   input  logic          swap_req,
   output logic          load_ready,
   output logic          wr_en,
   output logic [SW-1:0] wr_idx,
   output logic          swap
);
   localparam logic [SW-1:0] LAST_IDX = SW'(NSTORE - 1);

   load_state_e   state_q, state_d;
   logic [SW-1:0] idx_q, idx_d;
   logic          accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Abort has priority over both an accept and a swap in every state.
   always_comb begin
      accept  = load_valid && (state_q != PENDING);
      state_d = state_q;
      idx_d   = idx_q;
      if (load_abort) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE, LOADING: begin
               if (accept) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = PENDING;
                  end else begin
                     state_d = LOADING;
                     idx_d   = idx_q + 1'b1;
                  end
               end
            end
            PENDING: begin
               if (swap_req) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      load_ready = (state_q != PENDING);
      wr_en      = load_ready && load_valid && !load_abort;
      wr_idx     = idx_q;
      swap       = (state_q == PENDING) && swap_req && !load_abort;
   end

endmodule

// File: rtl/banco_coeficientes.sv
// Double-buffered FIR coefficient store: MAC reads the active bank, host fills the shadow bank.
// Read latency 1 cycle; load_ready low while a full set awaits swap_req, bank flip takes effect next cycle.
module banco_coeficientes
   import fir_pkg::*;
#(
   parameter int COEF_W    = COEF_W_DEF,
   parameter int TAPS      = 8,
   parameter int SYMMETRIC = 0
) (
   input  logic                clk,
   input  logic                rst,
   banco_coeficientes_if.slave bus
);
   localparam int AW     = $clog2(TAPS);
   localparam int NSTORE = nstore_calc(TAPS, SYMMETRIC);
   localparam int SW     = idx_width(NSTORE);

   logic              wr_en;
   logic              swap;
   logic [SW-1:0]     wr_idx;
   logic              shadow_sel;

   logic [COEF_W-1:0] bank_q [2][NSTORE];
   logic [COEF_W-1:0] bank_d [2][NSTORE];
   logic              bank_sel_q, bank_sel_d;
   logic              swap_done_q, swap_done_d;
   logic              coef_valid_q, coef_valid_d;
   logic [COEF_W-1:0] coef_q, coef_d;

   logic [AW-1:0]     rd_addr;
   logic [31:0]       addr_w, mirror_w, eff_w;
   logic              in_range;
   logic [SW-1:0]     rd_idx;

   cargador_coeficientes #(
      .NSTORE (NSTORE),
      .SW     (SW)
   ) u_cargador (
      .clk        (clk),
      .rst        (rst),
      .load_valid (bus.load_valid),
      .load_abort (bus.load_abort),
      .swap_req   (bus.swap_req),
      .load_ready (bus.load_ready),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .swap       (swap)
   );

   // In symmetric mode the upper half of the taps folds onto the lower half.
   always_comb begin
      rd_addr  = bus.contador_arriba;
      addr_w   = 32'(rd_addr);
      mirror_w = 32'(TAPS - 1) - addr_w;
      in_range = addr_w < 32'(TAPS);
      eff_w    = ((SYMMETRIC != 0) && (mirror_w < addr_w)) ? mirror_w : addr_w;
      rd_idx   = SW'(eff_w);
   end

   // Reads use the pre-swap bank_sel, so a read in the swap cycle still sees the old set.
   always_comb begin
      shadow_sel = ~bank_sel_q;
      bank_d     = bank_q;
      if (wr_en) begin
         bank_d[shadow_sel][wr_idx] = bus.load_data;
      end
      bank_sel_d   = bank_sel_q ^ swap;
      swap_done_d  = swap;
      coef_valid_d = bus.rd_en;
      coef_d       = coef_q;
      if (bus.rd_en) begin
         coef_d = in_range ? bank_q[bank_sel_q][rd_idx] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NSTORE; i++) begin
               bank_q[b][i] <= COEF_W'(DEFAULT[i % NDEF]);
            end
         end
         bank_sel_q   <= 1'b0;
         swap_done_q  <= 1'b0;
         coef_valid_q <= 1'b0;
         coef_q       <= '0;
      end else begin
         bank_q       <= bank_d;
         bank_sel_q   <= bank_sel_d;
         swap_done_q  <= swap_done_d;
         coef_valid_q <= coef_valid_d;
         coef_q       <= coef_d;
      end
   end

   assign bus.coeficiente = coef_q;
   assign bus.coef_valid  = coef_valid_q;
   assign bus.swap_done   = swap_done_q;
   assign bus.bank_sel    = bank_sel_q;

endmodule

// File: tb/tb_banco_coeficientes.sv
// Bench for banco_coeficientes: three instances (plain 8-tap, symmetric 8-tap, plain 6-tap),
// directed corner sequences plus a randomized run against a bank-swapping reference model.
module tb_banco_coeficientes;

   typedef struct packed {
      logic [2:0]  addr;
      logic [20:0] exp_main;
      logic [20:0] exp_sym;
      logic [20:0] exp_t6;
   } rd_vec_t;

   logic    clk;
   logic    rst;
   int      errors;
   int      checks;
   rd_vec_t vecs [8];

   banco_coeficientes_if #(.COEF_W(21), .TAPS(8)) m_if ();
   banco_coeficientes_if #(.COEF_W(21), .TAPS(8)) s_if ();
   banco_coeficientes_if #(.COEF_W(21), .TAPS(6)) t_if ();

   banco_coeficientes #(.COEF_W(21), .TAPS(8), .SYMMETRIC(0)) u_dut (
      .clk (clk), .rst (rst), .bus (m_if.slave));
   banco_coeficientes #(.COEF_W(21), .TAPS(8), .SYMMETRIC(1)) u_sym (
      .clk (clk), .rst (rst), .bus (s_if.slave));
   banco_coeficientes #(.COEF_W(21), .TAPS(6), .SYMMETRIC(0)) u_t6 (
      .clk (clk), .rst (rst), .bus (t_if.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      m_if.rd_en = 0; m_if.contador_arriba = '0; m_if.load_valid = 0;
      m_if.load_data = '0; m_if.load_abort = 0; m_if.swap_req = 0;
      s_if.rd_en = 0; s_if.contador_arriba = '0; s_if.load_valid = 0;
      s_if.load_data = '0; s_if.load_abort = 0; s_if.swap_req = 0;
      t_if.rd_en = 0; t_if.contador_arriba = '0; t_if.load_valid = 0;
      t_if.load_data = '0; t_if.load_abort = 0; t_if.swap_req = 0;
   endtask

   task automatic main_accept(input logic [20:0] d);
      m_if.load_valid = 1;
      m_if.load_data  = d;
      tick();
      m_if.load_valid = 0;
   endtask

   task automatic check_main_seq(input string tag, input logic [20:0] first);
      for (int i = 0; i < 8; i++) begin
         m_if.rd_en = 1;
         m_if.contador_arriba = 3'(i);
         tick();
         chk($sformatf("%s[%0d]", tag, i), 32'(m_if.coeficiente), 32'(first + 21'(i)));
      end
      m_if.rd_en = 0;
   endtask

   task automatic check_defaults(input string tag);
      for (int i = 0; i < 8; i++) begin
         m_if.rd_en = 1; s_if.rd_en = 1; t_if.rd_en = 1;
         m_if.contador_arriba = vecs[i].addr;
         s_if.contador_arriba = vecs[i].addr;
         t_if.contador_arriba = vecs[i].addr;
         tick();
         chk($sformatf("%s_main[%0d]", tag, i), 32'(m_if.coeficiente), 32'(vecs[i].exp_main));
         chk($sformatf("%s_valid[%0d]", tag, i), 32'(m_if.coef_valid), 1);
         chk($sformatf("%s_sym[%0d]", tag, i), 32'(s_if.coeficiente), 32'(vecs[i].exp_sym));
         chk($sformatf("%s_t6[%0d]", tag, i), 32'(t_if.coeficiente), 32'(vecs[i].exp_t6));
      end
      m_if.rd_en = 0; s_if.rd_en = 0; t_if.rd_en = 0;
   endtask

   // Reference model state for the randomized run.
   logic [20:0] act [8];
   logic [20:0] shd [8];
   logic [20:0] tmp;
   int          nload;
   bit          pend;
   bit          bsel;
   logic [20:0] e_coef;
   bit          e_valid;
   bit          e_sd;

   initial begin
      logic [2:0]  sa [5];
      logic [20:0] se [5];
      logic        rd, lv, ab, sw;
      logic [2:0]  addr;
      logic [20:0] ld;

      errors = 0; checks = 0;
      clk = 0; rst = 1;
      idle_all();

      vecs[0] = '{3'd0, 21'h0B0000, 21'h0B0000, 21'h0B0000};
      vecs[1] = '{3'd1, 21'h098000, 21'h098000, 21'h098000};
      vecs[2] = '{3'd2, 21'h090000, 21'h090000, 21'h090000};
      vecs[3] = '{3'd3, 21'h0D2000, 21'h0D2000, 21'h0D2000};
      vecs[4] = '{3'd4, 21'h0C0000, 21'h0D2000, 21'h0C0000};
      vecs[5] = '{3'd5, 21'h086000, 21'h090000, 21'h086000};
      vecs[6] = '{3'd6, 21'h0A4000, 21'h098000, 21'h000000};
      vecs[7] = '{3'd7, 21'h08F000, 21'h0B0000, 21'h000000};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_coef", 32'(m_if.coeficiente), 0);
      chk("rst_valid", 32'(m_if.coef_valid), 0);
      chk("rst_swap_done", 32'(m_if.swap_done), 0);
      chk("rst_load_ready", 32'(m_if.load_ready), 1);
      chk("rst_bank_sel", 32'(m_if.bank_sel), 0);
      chk("rst_sym_load_ready", 32'(s_if.load_ready), 1);
      rst = 0;
      tick();

      check_defaults("def");
      tick();
      chk("hold_valid", 32'(m_if.coef_valid), 0);
      chk("hold_coef", 32'(m_if.coeficiente), 32'h08F000);

      // Load 1..8 with an early swap_req that must be ignored.
      for (int i = 1; i <= 8; i++) begin
         m_if.load_valid = 1;
         m_if.load_data  = 21'(i);
         m_if.swap_req   = (i == 4);
         tick();
         if (i == 4) begin
            chk("midload_bank_sel", 32'(m_if.bank_sel), 0);
            chk("midload_swap_done", 32'(m_if.swap_done), 0);
         end
         chk($sformatf("load_ready[%0d]", i), 32'(m_if.load_ready), (i < 8) ? 1 : 0);
      end
      m_if.load_valid = 0; m_if.swap_req = 0;
      tick();
      chk("pending_bank_sel", 32'(m_if.bank_sel), 0);
      chk("pending_ready", 32'(m_if.load_ready), 0);

      // Read in the swap cycle returns the old bank.
      m_if.swap_req = 1; m_if.rd_en = 1; m_if.contador_arriba = 3'd2;
      tick();
      chk("swapcyc_coef", 32'(m_if.coeficiente), 32'h090000);
      chk("swapcyc_swap_done", 32'(m_if.swap_done), 1);
      chk("swapcyc_bank_sel", 32'(m_if.bank_sel), 1);
      chk("swapcyc_ready", 32'(m_if.load_ready), 1);
      m_if.swap_req = 0;
      tick();
      chk("postswap_coef", 32'(m_if.coeficiente), 3);
      chk("postswap_swap_done", 32'(m_if.swap_done), 0);
      check_main_seq("swapped", 21'h1);

      // Abort after three words, with a fourth word offered in the abort cycle.
      for (int i = 0; i < 3; i++) main_accept(21'hA1 + 21'(i));
      m_if.load_valid = 1; m_if.load_data = 21'hA4; m_if.load_abort = 1;
      tick();
      m_if.load_valid = 0; m_if.load_abort = 0;
      chk("abort_ready", 32'(m_if.load_ready), 1);
      chk("abort_bank_sel", 32'(m_if.bank_sel), 1);
      check_main_seq("abort_active", 21'h1);
      for (int i = 0; i < 8; i++) begin
         main_accept(21'h101 + 21'(i));
         chk($sformatf("reload_ready[%0d]", i), 32'(m_if.load_ready), (i < 7) ? 1 : 0);
      end
      m_if.swap_req = 1;
      tick();
      m_if.swap_req = 0;
      chk("reload_swap_done", 32'(m_if.swap_done), 1);
      chk("reload_bank_sel", 32'(m_if.bank_sel), 0);
      check_main_seq("reload", 21'h101);

      // Abort while pending beats a simultaneous swap_req.
      for (int i = 0; i < 8; i++) main_accept(21'h55 + 21'(i));
      chk("pend2_ready", 32'(m_if.load_ready), 0);
      m_if.swap_req = 1; m_if.load_abort = 1;
      tick();
      m_if.swap_req = 0; m_if.load_abort = 0;
      chk("pendabort_bank_sel", 32'(m_if.bank_sel), 0);
      chk("pendabort_swap_done", 32'(m_if.swap_done), 0);
      chk("pendabort_ready", 32'(m_if.load_ready), 1);
      m_if.rd_en = 1; m_if.contador_arriba = 3'd5;
      tick();
      m_if.rd_en = 0;
      chk("pendabort_read", 32'(m_if.coeficiente), 32'h106);

      for (int i = 0; i < 8; i++) main_accept(21'h201 + 21'(i));
      m_if.swap_req = 1;
      tick();
      m_if.swap_req = 0;
      chk("third_bank_sel", 32'(m_if.bank_sel), 1);
      m_if.rd_en = 1; m_if.contador_arriba = 3'd0;
      tick();
      m_if.rd_en = 0;
      chk("third_read", 32'(m_if.coeficiente), 32'h201);

      // Symmetric instance: four stored words, mirrored reads.
      for (int i = 0; i < 4; i++) begin
         s_if.load_valid = 1;
         s_if.load_data  = 21'(8'h11 * (i + 1));
         tick();
         chk($sformatf("sym_ready[%0d]", i), 32'(s_if.load_ready), (i < 3) ? 1 : 0);
      end
      s_if.load_valid = 0; s_if.swap_req = 1;
      tick();
      s_if.swap_req = 0;
      chk("sym_swap_done", 32'(s_if.swap_done), 1);
      chk("sym_bank_sel", 32'(s_if.bank_sel), 1);
      sa[0] = 3'd7; se[0] = 21'h11;
      sa[1] = 3'd4; se[1] = 21'h44;
      sa[2] = 3'd0; se[2] = 21'h11;
      sa[3] = 3'd3; se[3] = 21'h44;
      sa[4] = 3'd5; se[4] = 21'h33;
      for (int i = 0; i < 5; i++) begin
         s_if.rd_en = 1; s_if.contador_arriba = sa[i];
         tick();
         chk($sformatf("sym_read[%0d]", sa[i]), 32'(s_if.coeficiente), 32'(se[i]));
      end
      s_if.rd_en = 0;

      // Reset in the middle of a load.
      for (int i = 0; i < 5; i++) main_accept(21'h77 + 21'(i));
      @(negedge clk);
      rst = 1;
      #1;
      chk("midrst_ready", 32'(m_if.load_ready), 1);
      chk("midrst_bank_sel", 32'(m_if.bank_sel), 0);
      chk("midrst_coef", 32'(m_if.coeficiente), 0);
      chk("midrst_sym_bank_sel", 32'(s_if.bank_sel), 0);
      tick();
      rst = 0;
      tick();
      check_defaults("postrst");

      // Randomized run against the reference model; both banks hold defaults now.
      for (int k = 0; k < 8; k++) begin
         act[k] = vecs[k].exp_main;
         shd[k] = vecs[k].exp_main;
      end
      nload = 0; pend = 0; bsel = 0; e_coef = 21'h08F000;
      for (int c = 0; c < 400; c++) begin
         rd   = ($urandom_range(0, 9) < 7);
         addr = 3'($urandom_range(0, 7));
         lv   = 1'($urandom_range(0, 1));
         ld   = 21'($urandom);
         ab   = ($urandom_range(0, 29) == 0);
         sw   = ($urandom_range(0, 7) == 0);
         m_if.rd_en = rd; m_if.contador_arriba = addr; m_if.load_valid = lv;
         m_if.load_data = ld; m_if.load_abort = ab; m_if.swap_req = sw;

         e_valid = rd;
         if (rd) e_coef = act[addr];
         e_sd = 0;
         if (ab) begin
            nload = 0;
            pend  = 0;
         end else if (pend) begin
            if (sw) begin
               for (int k = 0; k < 8; k++) begin
                  tmp = act[k]; act[k] = shd[k]; shd[k] = tmp;
               end
               bsel  = !bsel;
               e_sd  = 1;
               pend  = 0;
               nload = 0;
            end
         end else if (lv) begin
            shd[nload] = ld;
            nload++;
            if (nload == 8) pend = 1;
         end

         tick();
         checks++;
         if (m_if.coeficiente !== e_coef || m_if.coef_valid !== e_valid ||
             m_if.swap_done !== e_sd || m_if.load_ready !== !pend || m_if.bank_sel !== bsel) begin
            errors++;
            $display("FAIL rand[%0d]: got coef=%h valid=%b sd=%b rdy=%b bsel=%b expected coef=%h valid=%b sd=%b rdy=%b bsel=%b",
                     c, m_if.coeficiente, m_if.coef_valid, m_if.swap_done, m_if.load_ready, m_if.bank_sel,
                     e_coef, e_valid, e_sd, !pend, bsel);
         end
      end
      idle_all();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/banco_coeficientes.md
# banco_coeficientes

Double-buffered, run-time loadable coefficient store for the FIR audio filter datapath. It replaces the fixed 8-entry coefficient lookup with a parametrised bank pair. The MAC datapath reads the active bank by tap index while a host loads a new set into the shadow bank over a valid/ready stream. A completed set becomes active only on a frame boundary (`swap_req`), so one output sample never mixes two coefficient sets.

## Interface
- `COEF_W`, 21: coefficient width in bits.
- `TAPS`, 8: number of filter taps; must be at least 2.
- `SYMMETRIC`, 0: when 1, only `NSTORE = ceil(TAPS/2)` words are stored and loaded; tap `i` and tap `TAPS-1-i` read the same word.
- `AW`, `$clog2(TAPS)`: tap address width (derived; do not override).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: read request.
- `contador_arriba` in AW: tap index to read.
- `coeficiente` out COEF_W: registered coefficient.
- `coef_valid` out 1: `coeficiente` holds data for the previous cycle's request.
- `load_valid` in 1: host offers `load_data`.
- `load_data` in COEF_W: next coefficient; words are taken in order, starting at index 0.
- `load_ready` out 1: shadow bank accepts a word.
- `load_abort` in 1: discard a partial or pending load.
- `swap_req` in 1: frame-boundary pulse from the FIR controller.
- `swap_done` out 1: one-cycle pulse when the active bank flipped.
- `bank_sel` out 1: index of the active bank.

## Operation
- Storage: two arrays, each `NSTORE × COEF_W`. Both arrays are asynchronously reset.
- Reset defaults (`TAPS=8`, `SYMMETRIC=0`), index 0..7: 0x0B0000, 0x098000, 0x090000, 0x0D2000, 0x0C0000, 0x086000, 0x0A4000, 0x08F000.
  - For other `TAPS`, default index `i` holds `DEFAULT[i mod 8]`.
  - In symmetric mode, stored word `i` defaults to `DEFAULT[i]`.
- Reset values: `bank_sel`=0, `coeficiente`=0, `coef_valid`=0, `swap_done`=0, `load_ready`=1, load FSM in IDLE, write index 0.
- Read path:
  - Effective index = `contador_arriba` when `SYMMETRIC=0`.
  - When `SYMMETRIC=1`, effective index = `min(a, TAPS-1-a)`, where `a = contador_arriba`.
  - An address of `TAPS` or more returns 0 with `coef_valid`=1.
  - When `rd_en`=0, `coeficiente` holds its value and `coef_valid`=0.
- Load FSM:
  - IDLE: first accepted word writes index 0 and moves to LOADING.
  - LOADING: each accept writes the shadow bank at the write index, then increments it. The accept that writes index `NSTORE-1` moves to PENDING. When `NSTORE`=1, that first accept goes straight from IDLE to PENDING.
  - PENDING: `load_ready`=0. `swap_req` toggles `bank_sel`, pulses `swap_done`, clears the write index and returns to IDLE.
  - `swap_req` in IDLE or LOADING is ignored.
  - `load_abort` in LOADING or PENDING returns to IDLE and clears the write index. The shadow contents are undefined and the active bank is untouched.
- Priority: `load_abort` wins over a simultaneous accept or `swap_req`.
- After a swap, the shadow bank holds the previous set until it is overwritten.

## Timing
- Read latency is 1 cycle: a request at edge N presents data after edge N+1.
- A read in the same cycle as an accepted `swap_req` returns the old bank. The first read issued after the swap returns the new bank.
- Accept condition: `load_valid && load_ready` at the rising edge.
- After the last accept, `load_ready` goes low immediately after that edge.
- After a swap, `load_ready` is high again right after the swap edge. `swap_done` is high for exactly that one cycle.
- Writes target only the shadow bank, so a read never returns a half-written word.
- Reset mid-load or mid-swap: all state, including both arrays, returns to the reset defaults.

## Structure
- Shared package `fir_pkg` holds:
  - `COEF_W_DEF` (= 21).
  - The `DEFAULT` coefficient constant array.
  - The load FSM enum: IDLE, LOADING, PENDING.
  - The `NSTORE` computation function.
- One sub-module, `cargador_coeficientes`, contains the load FSM, the write index and the handshake and swap logic. It outputs the write strobe, write index and swap strobe.
- The top level holds the two arrays, the `bank_sel` register and the registered read mux.

## Test plan
- Reset defaults: reset, then read addresses 0..7 back-to-back → 0x0B0000 … 0x08F000, each one cycle after its request. Address 7 with `TAPS=8` is a valid read; at `TAPS=6`, address 7 → 0.
- Load and swap: load words 0x000001..0x000008, pulsing `swap_req` mid-load. The mid-load `swap_req` is ignored (`bank_sel` stays 0). Check `load_ready`=0 after the 8th accept. Pulse `swap_req` → `swap_done` for one cycle, `bank_sel`=1, and reads 0..7 return 0x000001..0x000008.
- Swap-cycle read: issue a read of address 2 in the same cycle as `swap_req` → returns the old value. The next read of address 2 → new value.
- Abort: accept 3 words, then `load_abort` together with `load_valid`. Expect IDLE, the 4th word not written, active reads unchanged. A fresh 8-word load plus swap then succeeds.
- Symmetric mode: `SYMMETRIC=1`, `TAPS=8`. Load 4 words 0x11, 0x22, 0x33, 0x44 and swap. Address 7 → 0x11 and address 4 → 0x44.
- Reset mid-load: assert `rst` after 5 accepts → `load_ready`=1, `bank_sel`=0, and defaults are restored in both banks.
